// File: rtl/bit_counter_pkg.sv
// Shared types and helpers for the bit-counter arbiter: FSM state encoding,
// result width calculation and packed operand slicing.
package bit_counter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } arb_state_t;

    function automatic int res_width(input int width);
        return $clog2(width + 1);
    endfunction

    // LSB of requester idx's operand inside the packed req_data bus.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/bit_counter_arbiter_if.sv
// Requester bus plus the link to the shared bit_counter instance.
// The arbiter takes the slave view; game logic and the counter take the master view.
interface bit_counter_arbiter_if
    import bit_counter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int RES_W = res_width(WIDTH),
    parameter int ID_W  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       ack;
    logic [RES_W-1:0]      result;
    logic [ID_W-1:0]       result_id;
    logic                  busy;
    logic                  timeout_err;
    logic                  cnt_s;
    logic [WIDTH-1:0]      cnt_a;
    logic                  cnt_done;
    logic [RES_W-1:0]      cnt_result;

    modport slave (
        input  req, req_data, cnt_done, cnt_result,
        output grant, ack, result, result_id, busy, timeout_err, cnt_s, cnt_a
    );

    modport master (
        output req, req_data, cnt_done, cnt_result,
        input  grant, ack, result, result_id, busy, timeout_err, cnt_s, cnt_a
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after position last_i,
// wrapping modulo NREQ; valid_o is low when no request is pending.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] last_i,
    output logic [ID_W-1:0] winner_o,
    output logic            valid_o
);

    logic [ID_W-1:0] idx;

    // Scan farthest-first so the nearest pending request after last_i wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = ID_W'((int'(last_i) + i) % NREQ);
            if (req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_counter_arbiter.sv
// Round-robin front end that time-shares one bit_counter between NREQ requesters:
// latch operand, pulse start, wait for done (with watchdog), ack the owner.
//
// state   | meaning
// S_IDLE  | no transaction; arbitrate pending requests
// S_START | operand latched, grant high, cnt_s pulsed this cycle
// S_WAIT  | waiting for cnt_done; watchdog running
// S_RESP  | ack pulse to the owner, result valid; grant drops after this cycle
module bit_counter_arbiter
    import bit_counter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = WIDTH + 4
) (
    input logic               clk,
    input logic               reset,
    bit_counter_arbiter_if.slave bus
);

    localparam int RES_W = res_width(WIDTH);
    localparam int ID_W  = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [ID_W-1:0]  winner_q, winner_d;
    logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [ID_W-1:0]  result_id_q, result_id_d;
    logic             timeout_err_q, timeout_err_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    logic [ID_W-1:0]  arb_winner;
    logic             arb_valid;
    logic [WIDTH-1:0] words [NREQ];
    logic [NREQ-1:0]  owner_oh;

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = bus.req_data[slice_lsb(g, WIDTH) +: WIDTH];
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i    (bus.req),
        .last_i   (last_q),
        .winner_o (arb_winner),
        .valid_o  (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_q        <= ID_W'(NREQ - 1);
            winner_q      <= '0;
            cnt_a_q       <= '0;
            result_q      <= '0;
            result_id_q   <= '0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            winner_q      <= winner_d;
            cnt_a_q       <= cnt_a_d;
            result_q      <= result_d;
            result_id_q   <= result_id_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        winner_d      = winner_q;
        cnt_a_d       = cnt_a_q;
        result_d      = result_q;
        result_id_d   = result_id_q;
        timeout_err_d = timeout_err_q;
        wdog_d        = wdog_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    winner_d = arb_winner;
                    last_d   = arb_winner;
                    cnt_a_d  = words[arb_winner];
                    state_d  = S_START;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done seen on the last watchdog cycle still counts as success.
                if (bus.cnt_done) begin
                    result_d    = bus.cnt_result;
                    result_id_d = winner_q;
                    state_d     = S_RESP;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    result_d      = '0;
                    result_id_d   = winner_q;
                    timeout_err_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign owner_oh        = NREQ'(1) << winner_q;
    assign bus.grant       = (state_q != S_IDLE) ? owner_oh : '0;
    assign bus.ack         = (state_q == S_RESP) ? owner_oh : '0;
    assign bus.cnt_s       = (state_q == S_START);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.cnt_a       = cnt_a_q;
    assign bus.result      = result_q;
    assign bus.result_id   = result_id_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bit_counter_arbiter.sv
// Self-checking bench for bit_counter_arbiter: behavioural shared counter,
// table-driven single transactions, directed corner sequences, random traffic.
module tb_bit_counter_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;

    bit_counter_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    bit_counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    function automatic int popcount(input logic [WIDTH-1:0] w);
        int c = 0;
        for (int i = 0; i < WIDTH; i++) c += int'(w[i]);
        return c;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural shared counter: starts on cnt_s, answers lat cycles later with a
    // one-cycle done; hang suppresses done entirely.
    bit hang = 0;
    bit rand_lat = 0;
    int lat_cfg = 0;
    bit m_busy = 0;
    int m_delay = 0;
    logic [WIDTH-1:0] m_word;
    int s_pulses = 0;

    always @(negedge clk) begin
        if (bus.cnt_s) s_pulses++;
        if (reset) begin
            m_busy = 0;
            bus.cnt_done = 1'b0;
            bus.cnt_result = '0;
        end else if (bus.cnt_s) begin
            m_busy = 1;
            m_word = bus.cnt_a;
            m_delay = rand_lat ? int'($urandom_range(0, 8)) : lat_cfg;
            bus.cnt_done = 1'b0;
        end else if (m_busy && !hang) begin
            if (m_delay == 0) begin
                bus.cnt_done = 1'b1;
                bus.cnt_result = 4'(popcount(m_word));
                m_busy = 0;
            end else begin
                m_delay--;
                bus.cnt_done = 1'b0;
            end
        end else begin
            bus.cnt_done = 1'b0;
        end
    end

    task automatic set_word(input int i, input logic [WIDTH-1:0] w);
        bus.req_data[i*WIDTH +: WIDTH] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int id, output int cycles);
        id = -1;
        cycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cycles++;
            if (bus.grant != '0) begin
                id = onehot_idx(bus.grant);
                return;
            end
        end
        fail_now("grant_wait");
    endtask

    task automatic wait_ack(output int id, output logic [3:0] res, output int cycles);
        id = -1;
        res = '0;
        cycles = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cycles++;
            if (bus.ack != '0) begin
                id = onehot_idx(bus.ack);
                res = bus.result;
                check("ack_onehot", 32'($countones(bus.ack)), 1);
                check("result_id", 32'(bus.result_id), 32'(id));
                return;
            end
        end
        fail_now("ack_wait");
    endtask

    typedef struct {
        int id;
        logic [WIDTH-1:0] word;
        int exp_res;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int id, cyc, s0, exp_id, owner, stall, model_last;
        logic [3:0] res;
        logic [WIDTH-1:0] words_q[NREQ];
        logic [WIDTH-1:0] owner_word;
        int exp_ids[5];
        int exp_res[5];

        vecs[0] = '{0, 8'hB5, 5};
        vecs[1] = '{1, 8'hFF, 8};
        vecs[2] = '{2, 8'h00, 0};
        vecs[3] = '{3, 8'h81, 2};
        vecs[4] = '{0, 8'h0F, 4};
        vecs[5] = '{1, 8'h80, 1};
        vecs[6] = '{2, 8'h7E, 6};
        vecs[7] = '{3, 8'hFE, 7};

        reset = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_result_id", 32'(bus.result_id), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_timeout", 32'(bus.timeout_err), 0);
        check("rst_cnt_s", 32'(bus.cnt_s), 0);
        check("rst_cnt_a", 32'(bus.cnt_a), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single transactions from an idle block
        foreach (vecs[v]) begin
            lat_cfg = v % 4;
            s0 = s_pulses;
            set_word(vecs[v].id, vecs[v].word);
            bus.req[vecs[v].id] = 1'b1;
            wait_grant(id, cyc);
            check("tbl_grant", 32'(bus.grant), 32'(1 << vecs[v].id));
            check("tbl_grant_lat", 32'(cyc), 1);
            check("tbl_cnt_a", 32'(bus.cnt_a), 32'(vecs[v].word));
            wait_ack(id, res, cyc);
            bus.req[vecs[v].id] = 1'b0;
            check("tbl_ack_id", 32'(id), 32'(vecs[v].id));
            check("tbl_result", 32'(res), 32'(vecs[v].exp_res));
            check("tbl_ack_lat", 32'(cyc), 32'(lat_cfg + 2));
            check("tbl_s_pulses", 32'(s_pulses - s0), 1);
            @(negedge clk);
            check("tbl_busy_after", 32'(bus.busy), 0);
            check("tbl_result_held", 32'(bus.result), 32'(vecs[v].exp_res));
            check("tbl_ack_after", 32'(bus.ack), 0);
        end

        // All four requesting: strict rotation 0,1,2,3 then back to 0
        do_reset();
        lat_cfg = 1;
        set_word(0, 8'h00); set_word(1, 8'hFF); set_word(2, 8'h0F); set_word(3, 8'h81);
        bus.req = 4'b1111;
        exp_ids = '{0, 1, 2, 3, 0};
        exp_res = '{0, 8, 4, 2, 0};
        for (int k = 0; k < 5; k++) begin
            wait_ack(id, res, cyc);
            check("rot_id", 32'(id), 32'(exp_ids[k]));
            check("rot_result", 32'(res), 32'(exp_res[k]));
        end
        bus.req = '0;

        // Rotation from last=2: req[3] beats req[1]
        do_reset();
        set_word(2, 8'h3C);
        bus.req[2] = 1'b1;
        wait_ack(id, res, cyc);
        check("rr3_first", 32'(id), 2);
        bus.req[2] = 1'b0;
        set_word(1, 8'h01); set_word(3, 8'h07);
        bus.req[1] = 1'b1; bus.req[3] = 1'b1;
        wait_ack(id, res, cyc);
        check("rr3_second", 32'(id), 3);
        check("rr3_second_res", 32'(res), 3);
        bus.req[3] = 1'b0;
        wait_ack(id, res, cyc);
        check("rr3_third", 32'(id), 1);
        check("rr3_third_res", 32'(res), 1);
        bus.req[1] = 1'b0;

        // Operand change and req drop after grant do not abort
        lat_cfg = 4;
        @(negedge clk);
        set_word(0, 8'hF0);
        bus.req[0] = 1'b1;
        wait_grant(id, cyc);
        check("latch_cnt_a", 32'(bus.cnt_a), 32'hF0);
        @(negedge clk);
        set_word(0, 8'h01);
        bus.req[0] = 1'b0;
        wait_ack(id, res, cyc);
        check("latch_id", 32'(id), 0);
        check("latch_result", 32'(res), 4);

        // Random traffic against the round-robin reference model
        do_reset();
        rand_lat = 1;
        model_last = NREQ - 1;
        owner = -1;
        owner_word = '0;
        stall = 0;
        for (int i = 0; i < NREQ; i++) words_q[i] = '0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            if (bus.grant != '0 && owner == -1) begin
                exp_id = rr_pick(bus.req, model_last);
                if (exp_id < 0) begin
                    fail_now("rnd_grant_no_req");
                end else begin
                    check("rnd_grant", 32'(bus.grant), 32'(1 << exp_id));
                    owner = exp_id;
                    owner_word = words_q[exp_id];
                    model_last = exp_id;
                end
            end
            if (bus.ack != '0) begin
                stall = 0;
                if (owner < 0) begin
                    fail_now("rnd_spurious_ack");
                end else begin
                    check("rnd_ack", 32'(bus.ack), 32'(1 << owner));
                    check("rnd_result", 32'(bus.result), 32'(popcount(owner_word)));
                    check("rnd_result_id", 32'(bus.result_id), 32'(owner));
                    if ($urandom_range(0, 1) == 0) bus.req[owner] = 1'b0;
                    owner = -1;
                end
            end else if (bus.req != '0) begin
                stall++;
                if (stall > 40) begin
                    fail_now("rnd_stall");
                    stall = 0;
                end
            end else begin
                stall = 0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (i == owner) begin
                    if ($urandom_range(0, 7) == 0) begin
                        words_q[i] = 8'($urandom);
                        set_word(i, words_q[i]);
                    end
                    if ($urandom_range(0, 7) == 0) bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    words_q[i] = 8'($urandom);
                    set_word(i, words_q[i]);
                    bus.req[i] = 1'b1;
                end
            end
        end
        bus.req = '0;
        rand_lat = 0;
        repeat (30) @(negedge clk);
        check("rnd_no_timeout", 32'(bus.timeout_err), 0);

        // Hung counter: 12 cycles in S_WAIT then ack with result 0; error sticks
        lat_cfg = 2;
        hang = 1;
        set_word(1, 8'hFF);
        bus.req[1] = 1'b1;
        wait_grant(id, cyc);
        check("to_err_before", 32'(bus.timeout_err), 0);
        wait_ack(id, res, cyc);
        bus.req[1] = 1'b0;
        hang = 0;
        check("to_ack_id", 32'(id), 1);
        check("to_ack_lat", 32'(cyc), 13);
        check("to_result", 32'(res), 0);
        check("to_err_set", 32'(bus.timeout_err), 1);
        set_word(2, 8'h0F);
        bus.req[2] = 1'b1;
        wait_ack(id, res, cyc);
        bus.req[2] = 1'b0;
        check("to_next_result", 32'(res), 4);
        check("to_err_sticky", 32'(bus.timeout_err), 1);

        // Reset during S_WAIT aborts silently
        hang = 1;
        set_word(2, 8'hAA);
        bus.req[2] = 1'b1;
        wait_grant(id, cyc);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        @(negedge clk);
        check("mid_rst_grant", 32'(bus.grant), 0);
        check("mid_rst_cnt_s", 32'(bus.cnt_s), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_ack", 32'(bus.ack), 0);
        check("mid_rst_timeout", 32'(bus.timeout_err), 0);
        hang = 0;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_rst_no_ack", 32'(bus.ack), 0);
        end
        set_word(1, 8'h77);
        bus.req[1] = 1'b1;
        wait_ack(id, res, cyc);
        bus.req[1] = 1'b0;
        check("post_rst_id", 32'(id), 1);
        check("post_rst_result", 32'(res), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_counter_arbiter.md
Name: bit_counter_arbiter

Overview:
- Shares one bit_counter datapath/controller pair (ports s, A operand, done, result) between NREQ requesters.
- Each requester presents a WIDTH-bit word and holds req. The block picks a requester round-robin, latches its word and launches the counter with a one-cycle start pulse.
- It waits for done, then returns the ones-count to that requester with a one-cycle ack.
- Sits between game logic (Blackjack hand/deck evaluators) and the single shared counter instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand width of the shared counter
RES_W, $clog2(WIDTH+1), result width (4 for WIDTH=8)
TIMEOUT, WIDTH+4, max cycles in S_WAIT before declaring the counter hung

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level; held until matching ack
req_data  in  NREQ*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH]
grant  out  NREQ  one-hot; high from launch until ack of the owning requester
ack  out  NREQ  one-hot, one-cycle pulse; result valid in the same cycle
result  out  RES_W  ones-count of the granted word; held until next ack
result_id  out  $clog2(NREQ)  index of the requester served by the last ack
busy  out  1  high in every state except S_IDLE
timeout_err  out  1  sticky; set on counter timeout, cleared only by reset
cnt_s  out  1  start to the shared counter controller
cnt_a  out  WIDTH  operand to the counter datapath (latched word)
cnt_done  in  1  done from the counter controller
cnt_result  in  RES_W  counter result register

Behaviour:
- Reset: state S_IDLE. grant=0, ack=0, result=0, result_id=0, busy=0, timeout_err=0, cnt_s=0, cnt_a=0. Round-robin pointer last=NREQ-1, so req[0] has top priority first.
- States:
  - S_IDLE: if any req is high, pick the first high req scanning last+1, last+2 … (mod NREQ). Latch req_data of the winner into cnt_a, set grant[winner], update last=winner, go to S_START. Otherwise stay in S_IDLE.
  - S_START: cnt_s=1 for exactly this cycle; go to S_WAIT.
  - S_WAIT: cnt_s=0. Watchdog counts up from 0.
    - If cnt_done=1: capture cnt_result into result and go to S_RESP.
    - Else if watchdog reaches TIMEOUT-1: set result=0, set timeout_err=1, go to S_RESP.
  - S_RESP: ack[winner]=1 for this cycle, result_id=winner, grant cleared at the end of the cycle, go to S_IDLE.
- Because cnt_s=0 when done is sampled, the counter returns to its idle state on the next edge. The next launch is therefore never earlier than 2 cycles after S_RESP.
- Latency: req sampled in S_IDLE at edge k gives grant at k+1, cnt_s high during cycle k+1, and ack in the cycle after cnt_done is first seen high.
- Operand is latched at grant. Later changes to req_data, or dropping req before ack, do not abort the transaction; ack is still pulsed.
- New requests arriving while busy are only arbitrated in S_IDLE; there is no preemption.
- Fairness: with all req held high, service order is 0,1,2,…,NREQ-1,0. No requester is served twice while another is continuously requesting.
- A requester that keeps req high after its ack is eligible again only by rotation.
- Reset mid-operation (any state): immediate return to reset values on that edge. No ack is issued for the aborted transaction, and cnt_s=0.
- Watchdog is cleared on entry to S_WAIT.

Decomposition:
- Shared package bit_counter_pkg:
  - arb_state_t enum {S_IDLE, S_START, S_WAIT, S_RESP};
  - localparam function for RES_W;
  - the packed req_data slicing helper.
- One sub-module rr_arbiter (combinational next-winner from req and last, plus valid flag), parameterised by NREQ.

Test Plan:
1. After reset, req[0]=1, req_data[0]=8'hB5, counter model behaving -> grant=4'b0001, one cnt_s pulse, ack=4'b0001 pulse with result=5, result_id=0, busy falls after S_RESP.
2. req=4'b1111 with words 8'h00, 8'hFF, 8'h0F, 8'h81 held throughout -> acks in order 0,1,2,3 with results 0,8,4,2; next grant goes to 0.
3. Serve req[2], then raise req[1] and req[3] together -> req[3] served before req[1] (rotation from last=2).
4. Change req_data[0] and drop req[0] one cycle after grant -> result reflects the originally latched word; ack[0] still pulses.
5. Tie cnt_done=0 -> after 12 cycles in S_WAIT, ack pulses with result=0 and timeout_err=1; it stays 1 through later normal transactions until reset.
6. Assert reset during S_WAIT -> next cycle grant=0, cnt_s=0, busy=0, no ack. A subsequent req[1] is served normally with req[0] idle.
